// File: rtl/clk_gate_sched_if.sv
// Key/mode inputs and clock-enable/status outputs of clk_gate_sched.
// CLK_GATE_SCHED_STATUS_EN adds the sw_cnt_o switch counter.
interface clk_gate_sched_if;
    logic [1:0]  key_i;
    logic        mode_i;
    logic [1:0]  ce_o;
    logic        busy_o;
`ifdef CLK_GATE_SCHED_STATUS_EN
    logic [15:0] sw_cnt_o;

    modport master (output key_i, mode_i, input ce_o, busy_o, sw_cnt_o);
    modport slave  (input key_i, mode_i, output ce_o, busy_o, sw_cnt_o);
`else
    modport master (output key_i, mode_i, input ce_o, busy_o);
    modport slave  (input key_i, mode_i, output ce_o, busy_o);
`endif
endinterface

// File: rtl/clk_gate_sched.sv
// Two-domain DQCE clock-enable scheduler: debounced manual toggles or auto alternation with gaps.
// Optional macro CLK_GATE_SCHED_STATUS_EN adds sw_cnt_o, a saturating count of ce_o changes.
//
// state  | meaning
// MANUAL | ce_o follows en_req, key presses toggle en_req
// RUN0   | channel 0 enabled for the dwell time
// GAP0   | both off, handing over to channel 1
// RUN1   | channel 1 enabled for the dwell time
// GAP1   | both off, handing over to channel 0
module clk_gate_sched #(
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter int unsigned DWELL_CYCLES    = 13500000,
    parameter int unsigned GAP_CYCLES      = 4
) (
    input logic             clk,
    input logic             rst_i,
    clk_gate_sched_if.slave bus
);
    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned CNT_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_TOP    = CNT_W'(CNT_MAX);

    typedef enum logic [2:0] {MANUAL, RUN0, GAP0, RUN1, GAP1} state_t;

    logic [1:0]      key_s1, key_s2;
    logic            mode_s1, mode_s2;
    logic [1:0]      key_deb, press;
    logic [DB_W-1:0] db_cnt [2];
    state_t          state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]      en_req, en_req_nxt;
    logic [1:0]      ce_q, ce_nxt;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            key_s1  <= 2'b00;
            key_s2  <= 2'b00;
            mode_s1 <= 1'b0;
            mode_s2 <= 1'b0;
        end else begin
            key_s1  <= bus.key_i;
            key_s2  <= key_s1;
            mode_s1 <= bus.mode_i;
            mode_s2 <= mode_s1;
        end
    end

    // Press pulse is raised on the same edge the debounced level rises.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            key_deb <= 2'b00;
            press   <= 2'b00;
            for (int n = 0; n < 2; n++) db_cnt[n] <= '0;
        end else begin
            press <= 2'b00;
            for (int n = 0; n < 2; n++) begin
                if (key_s2[n] == key_deb[n]) begin
                    db_cnt[n] <= '0;
                end else if (db_cnt[n] == DB_LAST) begin
                    db_cnt[n]  <= '0;
                    key_deb[n] <= key_s2[n];
                    press[n]   <= key_s2[n];
                end else begin
                    db_cnt[n] <= db_cnt[n] + DB_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        en_req_nxt = en_req;
        ce_nxt     = 2'b00;
        case (state)
            MANUAL: begin
                en_req_nxt = en_req ^ press;
                if (mode_s2) state_nxt = GAP1;
            end
            RUN0: begin
                if (!mode_s2)                           state_nxt = MANUAL;
                else if (press[0] || cnt == DWELL_LAST) state_nxt = GAP0;
            end
            GAP0: begin
                if (!mode_s2)             state_nxt = MANUAL;
                else if (cnt == GAP_LAST) state_nxt = RUN1;
            end
            RUN1: begin
                if (!mode_s2)                           state_nxt = MANUAL;
                else if (press[0] || cnt == DWELL_LAST) state_nxt = GAP1;
            end
            GAP1: begin
                if (!mode_s2)             state_nxt = MANUAL;
                else if (cnt == GAP_LAST) state_nxt = RUN0;
            end
            default: state_nxt = MANUAL;
        endcase
        // ce_o is registered from the next state so it lines up with the state register.
        case (state_nxt)
            MANUAL:  ce_nxt = en_req;
            RUN0:    ce_nxt = 2'b01;
            RUN1:    ce_nxt = 2'b10;
            default: ce_nxt = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state  <= MANUAL;
            cnt    <= '0;
            en_req <= 2'b11;
            ce_q   <= 2'b00;
        end else begin
            state  <= state_nxt;
            en_req <= en_req_nxt;
            ce_q   <= ce_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else if (cnt != CNT_TOP)
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.ce_o   = ce_q;
    assign bus.busy_o = (state == GAP0) || (state == GAP1);

`ifdef CLK_GATE_SCHED_STATUS_EN
    logic [15:0] sw_cnt;

    always_ff @(posedge clk) begin
        if (rst_i)
            sw_cnt <= 16'h0000;
        else if (ce_nxt != ce_q && sw_cnt != 16'hFFFF)
            sw_cnt <= sw_cnt + 16'h0001;
    end

    assign bus.sw_cnt_o = sw_cnt;
`endif
endmodule

// File: doc/clk_gate_sched.md
CLK_GATE_SCHED -- requirements
Module: clk_gate_sched

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 270000: cycles a synchronized key level must be stable before it is accepted.
REQ-002 Parameter DWELL_CYCLES, default 13500000: cycles a channel stays enabled in auto mode.
REQ-003 Parameter GAP_CYCLES, default 4: cycles with both enables low between auto-mode handovers; legal range 1..255.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 key_i  input  2  raw asynchronous buttons, polarity already corrected, high = pressed; bit n serves channel n.
REQ-007 mode_i  input  1  asynchronous, 0 = manual, 1 = auto alternate.
REQ-008 ce_o  output  2  registered clock-enable for two DQCE gated-clock domains; bit n drives channel n CE.
REQ-009 busy_o  output  1  high while the FSM is in GAP0 or GAP1.

Function
REQ-010 key_i and mode_i SHALL each pass through a 2-flop synchronizer before any use.
REQ-011 Each key SHALL have an independent debouncer: debounced level takes the synchronized level after DEBOUNCE_CYCLES consecutive cycles of disagreement; any agreement restarts the count.
REQ-012 A debounced rising edge SHALL produce a registered one-cycle press pulse; falling edges produce nothing.
REQ-013 FSM states: MANUAL, RUN0, GAP0, RUN1, GAP1; one shared dwell/gap counter sized to DWELL_CYCLES.
REQ-014 MANUAL: press on key n toggles en_req[n]; ce_o <= en_req on the following cycle; both channels may be on at once.
REQ-015 Raw key held high from cycle t SHALL toggle ce_o[n] at exactly cycle t+DEBOUNCE_CYCLES+4.
REQ-016 Synchronized mode_i = 1 in MANUAL -> GAP1 with counter cleared.
REQ-017 RUN0: ce_o = 2'b01 for DWELL_CYCLES cycles, then GAP0; RUN1: ce_o = 2'b10 for DWELL_CYCLES cycles, then GAP1.
REQ-018 GAP0 -> RUN1 and GAP1 -> RUN0 after exactly GAP_CYCLES cycles with ce_o = 2'b00.
REQ-019 ce_o SHALL never transition directly between 2'b01 and 2'b10; an all-zero interval of at least GAP_CYCLES separates them.
REQ-020 In RUN0/RUN1, a key0 press SHALL end the dwell immediately (next state is the following GAP); key1 presses are ignored in auto states.
REQ-021 Synchronized mode_i = 0 in any auto state -> MANUAL on the next cycle; ce_o <= en_req; en_req is not modified in auto mode.
REQ-022 Mode change and key0 press in the same cycle: mode change wins.
REQ-023 Counter SHALL clear on every state change and never wrap.

Reset
REQ-024 rst_i high at a rising clk edge SHALL put state = MANUAL, en_req = 2'b11, ce_o = 2'b00, busy_o = 0, counters, synchronizers, debounced levels and press pulses = 0.
REQ-025 First cycle after reset deassertion: ce_o = 2'b11 (from en_req) unless mode is already 1 when synchronized.
REQ-026 Reset asserted mid-gap or mid-dwell SHALL abandon the sequence with no residual pulse.

Configuration
REQ-027 Macro CLK_GATE_SCHED_STATUS_EN defined: adds output sw_cnt_o (16 bits), counting cycles where ce_o changes value, saturating at 16'hFFFF, reset to 0.
REQ-028 Macro undefined: sw_cnt_o port and its logic are absent; all other behaviour is identical.

Verification (DEBOUNCE_CYCLES=4, DWELL_CYCLES=10, GAP_CYCLES=2)
REQ-029 Reset, mode_i=0, idle keys -> ce_o=2'b00 during reset and 2'b11 one cycle after deassertion.
REQ-030 key_i[0] high from cycle t -> ce_o=2'b10 at t+8; a 3-cycle glitch on key_i[1] -> no ce_o change.
REQ-031 mode_i=1 -> ce_o pattern 00,00 (busy_o=1), then 01 ×10, then 00 ×2, then 10 ×10, then repeats; no direct 01<->10 step.
REQ-032 Auto mode, key0 press during RUN0 cycle 3 -> GAP0 begins on the cycle after the press pulse; then RUN1 after 2 cycles.
REQ-033 en_req=2'b01 before auto, mode_i back to 0 in RUN1 -> ce_o=2'b01 and busy_o=0 after the sync delay plus 1.
REQ-034 With CLK_GATE_SCHED_STATUS_EN, one full auto cycle (4 ce_o changes) -> sw_cnt_o increments by 4; rst_i mid-RUN1 -> sw_cnt_o=0, ce_o=2'b00.
